// File: rtl/ip_codma_ap_req_gen.sv
// Address-phase request generator: splits a transfer descriptor into read/write
// burst entries of at most MAX_BURST_WORDS 64-bit words for the address-phase FIFO.
//
// state   | meaning
// IDLE    | waiting for start_i
// RD_REQ  | presenting read entry, pushes when FIFO not full
// RD_WAIT | waiting for rd_done_i
// WR_REQ  | presenting write entry, pushes when FIFO not full
// WR_WAIT | waiting for wr_done_i, then advance addresses
// DONE    | one-cycle completion
module ip_codma_ap_req_gen #(
  parameter int unsigned MAX_BURST_WORDS = 8
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [31:0] len_bytes_i,
  input  logic        stop_i,
  input  logic        bus_error_i,
  input  logic        ap_fifo_full_i,
  output logic        ap_push_o,
  output logic        ap_read_o,
  output logic        ap_write_o,
  output logic [31:0] ap_addr_o,
  output logic [3:0]  ap_size_o,
  input  logic        rd_done_i,
  input  logic        wr_done_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        cfg_error_o,
  output logic        xfer_error_o
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

  localparam logic [28:0] MAX_W = 29'(MAX_BURST_WORDS);
  localparam logic [3:0]  MAX_N = 4'(MAX_BURST_WORDS);

  state_t      state;
  logic [31:0] src_r;
  logic [31:0] dst_r;
  logic [28:0] words_left_r;
  logic [3:0]  burst_n;
  logic [31:0] step;
  logic [28:0] words_after;
  logic        in_req;
  logic        desc_bad;

  function automatic logic [3:0] clip(input logic [28:0] w);
    return (w < MAX_W) ? w[3:0] : MAX_N;
  endfunction

  assign burst_n     = clip(words_left_r);
  assign step        = {25'd0, burst_n, 3'b000};
  assign words_after = words_left_r - {25'd0, burst_n};
  assign in_req      = (state == RD_REQ) || (state == WR_REQ);
  assign desc_bad    = (len_bytes_i == 32'd0) || (len_bytes_i[2:0] != 3'd0) ||
                       (src_addr_i[2:0] != 3'd0) || (dst_addr_i[2:0] != 3'd0);

  // Push is the only output that must react to the FIFO and aborts in the same cycle.
  assign ap_push_o = in_req && !ap_fifo_full_i && !stop_i && !bus_error_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      src_r        <= '0;
      dst_r        <= '0;
      words_left_r <= '0;
      ap_read_o    <= 1'b0;
      ap_write_o   <= 1'b0;
      ap_addr_o    <= '0;
      ap_size_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      cfg_error_o  <= 1'b0;
      xfer_error_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (bus_error_i) begin
        state        <= IDLE;
        xfer_error_o <= 1'b1;
        busy_o       <= 1'b0;
        ap_read_o    <= 1'b0;
        ap_write_o   <= 1'b0;
      end else if (stop_i) begin
        state      <= IDLE;
        busy_o     <= 1'b0;
        ap_read_o  <= 1'b0;
        ap_write_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              cfg_error_o  <= 1'b0;
              xfer_error_o <= 1'b0;
              if (desc_bad) begin
                cfg_error_o <= 1'b1;
                done_o      <= 1'b1;
                state       <= DONE;
              end else begin
                src_r        <= src_addr_i;
                dst_r        <= dst_addr_i;
                words_left_r <= len_bytes_i[31:3];
                ap_addr_o    <= src_addr_i;
                ap_size_o    <= clip(len_bytes_i[31:3]);
                ap_read_o    <= 1'b1;
                busy_o       <= 1'b1;
                state        <= RD_REQ;
              end
            end
          end
          RD_REQ: begin
            if (!ap_fifo_full_i) begin
              ap_read_o <= 1'b0;
              state     <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (rd_done_i) begin
              ap_write_o <= 1'b1;
              ap_addr_o  <= dst_r;
              ap_size_o  <= burst_n;
              state      <= WR_REQ;
            end
          end
          WR_REQ: begin
            if (!ap_fifo_full_i) begin
              ap_write_o <= 1'b0;
              state      <= WR_WAIT;
            end
          end
          WR_WAIT: begin
            if (wr_done_i) begin
              src_r        <= src_r + step;
              dst_r        <= dst_r + step;
              words_left_r <= words_after;
              if (words_after == 29'd0) begin
                busy_o <= 1'b0;
                done_o <= 1'b1;
                state  <= DONE;
              end else begin
                ap_read_o <= 1'b1;
                ap_addr_o <= src_r + step;
                ap_size_o <= clip(words_after);
                state     <= RD_REQ;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ip_codma_ap_req_gen.sv
// Randomized bench for ip_codma_ap_req_gen; expected entries come from a
// descriptor-level model that chops the transfer into bursts.
module tb_ip_codma_ap_req_gen;
  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, bus_error, ap_fifo_full, rd_done, wr_done;
  logic [31:0] src, dst, len;
  logic        ap_push, ap_read, ap_write, busy, done, cfg_error, xfer_error;
  logic [31:0] ap_addr;
  logic [3:0]  ap_size;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  size;
  } ent_t;

  ip_codma_ap_req_gen #(.MAX_BURST_WORDS(MAXW)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
    .src_addr_i(src), .dst_addr_i(dst), .len_bytes_i(len),
    .stop_i(stop), .bus_error_i(bus_error), .ap_fifo_full_i(ap_fifo_full),
    .ap_push_o(ap_push), .ap_read_o(ap_read), .ap_write_o(ap_write),
    .ap_addr_o(ap_addr), .ap_size_o(ap_size),
    .rd_done_i(rd_done), .wr_done_i(wr_done),
    .busy_o(busy), .done_o(done), .cfg_error_o(cfg_error), .xfer_error_o(xfer_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_in();
    start = 1'b0; stop = 1'b0; bus_error = 1'b0;
    rd_done = 1'b0; wr_done = 1'b0; ap_fifo_full = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    clr_in();
  endtask

  task automatic finish_abort(input logic was_bus);
    cyc(); #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_push", 32'(ap_push), 0);
    chk("abort_read", 32'(ap_read), 0);
    chk("abort_write", 32'(ap_write), 0);
    chk("abort_xfer", 32'(xfer_error), 32'(was_bus));
    chk("abort_cfg", 32'(cfg_error), 0);
    cyc(); #1;
    chk("abort_idle_done", 32'(done), 0);
  endtask

  // ab_idx: entry index to abort at (-1 none); ab_phase 0 = request, 1 = wait.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                          input int full_pct, input int ab_idx, input int ab_phase,
                          input logic ab_bus);
    ent_t        q[$];
    ent_t        e;
    logic        bad;
    logic [28:0] w;
    logic [31:0] sa, da;
    logic [3:0]  b;
    int          nc, gap;
    logic        pushed, ab_here;

    bad = (l == 0) || (l[2:0] != 0) || (s[2:0] != 0) || (d[2:0] != 0);
    w = l[31:3]; sa = s; da = d;
    while (!bad && w != 0) begin
      b = (w < MAXW) ? w[3:0] : 4'(MAXW);
      e.rd = 1'b1; e.addr = sa; e.size = b; q.push_back(e);
      e.rd = 1'b0; e.addr = da; e.size = b; q.push_back(e);
      sa = sa + 32'(b) * 8; da = da + 32'(b) * 8;
      w = w - 29'(b);
    end

    cyc(); start = 1'b1; src = s; dst = d; len = l;
    if (bad) begin
      cyc(); #1;
      chk("inv_done", 32'(done), 1);
      chk("inv_cfg", 32'(cfg_error), 1);
      chk("inv_busy", 32'(busy), 0);
      chk("inv_push", 32'(ap_push), 0);
      cyc(); #1;
      chk("inv_done_clr", 32'(done), 0);
      chk("inv_push2", 32'(ap_push), 0);
      chk("inv_cfg_sticky", 32'(cfg_error), 1);
      return;
    end

    foreach (q[k]) begin
      nc = 0; pushed = 1'b0;
      while (!pushed) begin
        cyc();
        ab_here = (k == ab_idx) && (ab_phase == 0);
        ap_fifo_full = (nc < 5) && ($urandom_range(0, 99) < full_pct);
        if (q[k].rd) wr_done = 1'($urandom_range(0, 1));
        else         rd_done = 1'($urandom_range(0, 1));
        if (ab_here) begin
          ap_fifo_full = 1'b0;
          if (ab_bus) bus_error = 1'b1; else stop = 1'b1;
        end
        #1;
        chk("req_rd", 32'(ap_read), 32'(q[k].rd));
        chk("req_wr", 32'(ap_write), 32'(!q[k].rd));
        chk("req_addr", ap_addr, q[k].addr);
        chk("req_size", 32'(ap_size), 32'(q[k].size));
        chk("req_busy", 32'(busy), 1);
        if (ab_here) begin
          chk("abort_req_push", 32'(ap_push), 0);
          finish_abort(ab_bus);
          return;
        end
        chk("req_push", 32'(ap_push), 32'(!ap_fifo_full));
        pushed = !ap_fifo_full;
        nc++;
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g <= gap; g++) begin
        cyc();
        ab_here = (k == ab_idx) && (ab_phase == 1) && (g == gap);
        ap_fifo_full = 1'($urandom_range(0, 1));
        if (!q[k].rd) rd_done = 1'($urandom_range(0, 1));
        if (ab_here) begin
          if (ab_bus) bus_error = 1'b1; else stop = 1'b1;
        end else if (g == gap) begin
          if (q[k].rd) rd_done = 1'b1; else wr_done = 1'b1;
        end
        #1;
        chk("wait_push", 32'(ap_push), 0);
        chk("wait_busy", 32'(busy), 1);
        chk("wait_rd", 32'(ap_read), 0);
        chk("wait_wr", 32'(ap_write), 0);
        chk("wait_addr_hold", ap_addr, q[k].addr);
        chk("wait_size_hold", 32'(ap_size), 32'(q[k].size));
        if (ab_here) begin
          finish_abort(ab_bus);
          return;
        end
      end
    end

    cyc(); #1;
    chk("cmp_done", 32'(done), 1);
    chk("cmp_busy", 32'(busy), 0);
    chk("cmp_push", 32'(ap_push), 0);
    chk("cmp_cfg", 32'(cfg_error), 0);
    chk("cmp_xfer", 32'(xfer_error), 0);
    cyc(); #1;
    chk("cmp_done_pulse", 32'(done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rs, rd, rl;
    reset_n = 1'b0;
    clr_in();
    src = '0; dst = '0; len = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_push", 32'(ap_push), 0);
    chk("rst_read", 32'(ap_read), 0);
    chk("rst_write", 32'(ap_write), 0);
    chk("rst_addr", ap_addr, 0);
    chk("rst_size", 32'(ap_size), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg", 32'(cfg_error), 0);
    chk("rst_xfer", 32'(xfer_error), 0);
    reset_n = 1'b1;

    run_xfer(32'h1000, 32'h2000, 24, 0, -1, 0, 1'b0);
    run_xfer(32'h1000, 32'h2000, 136, 0, -1, 0, 1'b0);
    run_xfer(32'h1000, 32'h2000, 64, 100, -1, 0, 1'b0);
    run_xfer(32'h1000, 32'h2000, 12, 0, -1, 0, 1'b0);
    run_xfer(32'h1004, 32'h2000, 64, 0, -1, 0, 1'b0);
    run_xfer(32'h1000, 32'h2000, 0, 0, -1, 0, 1'b0);
    run_xfer(32'h1000, 32'h2004, 64, 0, -1, 0, 1'b0);
    run_xfer(32'h1000, 32'h2000, 24, 0, -1, 0, 1'b0);
    run_xfer(32'h1000, 32'h2000, 24, 0, 1, 0, 1'b0);
    run_xfer(32'h1000, 32'h2000, 24, 0, 0, 1, 1'b1);
    run_xfer(32'h1000, 32'h2000, 24, 0, -1, 0, 1'b0);
    run_xfer(32'hFFFF_FFC0, 32'h3000, 128, 30, -1, 0, 1'b0);

    // Reset while a read entry is pending behind a full FIFO.
    cyc(); start = 1'b1; src = 32'h3000; dst = 32'h4000; len = 64;
    cyc(); ap_fifo_full = 1'b1; #1;
    chk("prerst_read", 32'(ap_read), 1);
    chk("prerst_push", 32'(ap_push), 0);
    cyc(); reset_n = 1'b0; #1;
    chk("midrst_push", 32'(ap_push), 0);
    chk("midrst_read", 32'(ap_read), 0);
    chk("midrst_addr", ap_addr, 0);
    chk("midrst_size", 32'(ap_size), 0);
    chk("midrst_busy", 32'(busy), 0);
    cyc(); reset_n = 1'b1; #1;
    chk("postrst_busy", 32'(busy), 0);
    chk("postrst_push", 32'(ap_push), 0);

    for (int i = 0; i < 40; i++) begin
      rs = $urandom & 32'hFFFF_FFF8;
      rd = $urandom & 32'hFFFF_FFF8;
      rl = 32'($urandom_range(1, 40)) * 8;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       rl = 0;
          1:       rl = rl | 32'd4;
          2:       rs = rs | 32'd2;
          default: rd = rd | 32'd1;
        endcase
      end
      if ($urandom_range(0, 4) == 0)
        run_xfer(rs, rd, rl, 40, $urandom_range(0, 9), $urandom_range(0, 1),
                 1'($urandom_range(0, 1)));
      else
        run_xfer(rs, rd, rl, 40, -1, 0, 1'b0);
    end

    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
